// File: rtl/csr_pkg.sv
// Shared CSR address map and mstatus field definitions for the machine-mode CSR file.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  localparam logic [63:0] MSTATUS_WMASK = 64'h88;

  // Rebuild a full mstatus image from the fixed reset bits and the live MIE/MPIE flops.
  function automatic logic [63:0] mstatus_pack(input logic [63:0] base, input logic mie,
                                               input logic mpie);
    logic [63:0] v;
    v = base & ~MSTATUS_WMASK;
    v[MSTATUS_MIE]  = mie;
    v[MSTATUS_MPIE] = mpie;
    return v;
  endfunction

endpackage

// File: rtl/csr_mstatus_ctrl.sv
// mstatus MIE/MPIE interrupt-enable stack: trap entry, mret and software-write sequencing.
module csr_mstatus_ctrl
  import csr_pkg::*;
#(
  parameter logic [63:0] MSTATUS_RST = 64'h0000_000a_0000_1800
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_trap_en,
  input  logic        i_mret_en,
  input  logic        i_wr_en,
  input  logic        i_wr_mie,
  input  logic        i_wr_mpie,
  output logic [63:0] o_mstatus
);

  logic r_mie;
  logic r_mpie;
  logic w_mie_d;
  logic w_mpie_d;

  // Trap beats mret beats a software write; a simultaneous mret is dropped.
  always_comb begin
    w_mie_d  = r_mie;
    w_mpie_d = r_mpie;
    if (i_trap_en) begin
      w_mpie_d = r_mie;
      w_mie_d  = 1'b0;
    end else if (i_mret_en) begin
      w_mie_d  = r_mpie;
      w_mpie_d = 1'b1;
    end else if (i_wr_en) begin
      w_mie_d  = i_wr_mie;
      w_mpie_d = i_wr_mpie;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mie  <= MSTATUS_RST[MSTATUS_MIE];
      r_mpie <= MSTATUS_RST[MSTATUS_MPIE];
    end else begin
      r_mie  <= w_mie_d;
      r_mpie <= w_mpie_d;
    end
  end

  assign o_mstatus = mstatus_pack(MSTATUS_RST, r_mie, r_mpie);

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file serving the ALU CSR port; build with CSR_MCYCLE_EN defined to add
// a free-running mcycle counter at 0xB00.
module csr_regfile
  import csr_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter logic [63:0] MSTATUS_RST = 64'h0000_000a_0000_1800
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     CSR_Read_Addr,
  output logic [XLEN-1:0] CSR_Read_Data,
  input  logic [11:0]     CSR_Write_Addr,
  input  logic [XLEN-1:0] CSR_Write_Data,
  input  logic            Write_En,
  input  logic [XLEN-1:0] mcause_Write_Data,
  input  logic [XLEN-1:0] mepc_Write_Data,
  input  logic [XLEN-1:0] mtvec_Write_Data,
  input  logic            mcause_En,
  input  logic            mepc_En,
  input  logic            mtvec_En,
  output logic [XLEN-1:0] mcause_Read_Data,
  output logic [XLEN-1:0] mepc_Read_Data,
  output logic [XLEN-1:0] mtvec_Read_Data,
  input  logic            Trap_En,
  input  logic            Mret_En,
  output logic [XLEN-1:0] mstatus_Read_Data
);

  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] w_mstatus;
  logic [XLEN-1:0] w_rdata;

  logic w_wr_mstatus;
  logic w_wr_mtvec;
  logic w_wr_mscratch;
  logic w_wr_mepc;
  logic w_wr_mcause;

  assign w_wr_mstatus  = Write_En && (CSR_Write_Addr == CSR_MSTATUS);
  assign w_wr_mtvec    = Write_En && (CSR_Write_Addr == CSR_MTVEC);
  assign w_wr_mscratch = Write_En && (CSR_Write_Addr == CSR_MSCRATCH);
  assign w_wr_mepc     = Write_En && (CSR_Write_Addr == CSR_MEPC);
  assign w_wr_mcause   = Write_En && (CSR_Write_Addr == CSR_MCAUSE);

  csr_mstatus_ctrl #(
    .MSTATUS_RST (MSTATUS_RST)
  ) u_mstatus (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_trap_en (Trap_En),
    .i_mret_en (Mret_En),
    .i_wr_en   (w_wr_mstatus),
    .i_wr_mie  (CSR_Write_Data[MSTATUS_MIE]),
    .i_wr_mpie (CSR_Write_Data[MSTATUS_MPIE]),
    .o_mstatus (w_mstatus)
  );

  // Dedicated strobes outrank the generic write port on the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtvec    <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mscratch <= '0;
    end else begin
      if (mtvec_En)        r_mtvec <= mtvec_Write_Data & ~64'h3;
      else if (w_wr_mtvec) r_mtvec <= CSR_Write_Data & ~64'h3;

      if (mepc_En)        r_mepc <= mepc_Write_Data & ~64'h1;
      else if (w_wr_mepc) r_mepc <= CSR_Write_Data & ~64'h1;

      if (mcause_En)        r_mcause <= mcause_Write_Data;
      else if (w_wr_mcause) r_mcause <= CSR_Write_Data;

      if (w_wr_mscratch) r_mscratch <= CSR_Write_Data;
    end
  end

`ifdef CSR_MCYCLE_EN
  logic [XLEN-1:0] r_mcycle;

  // A software write replaces that cycle's increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcycle <= '0;
    end else if (Write_En && (CSR_Write_Addr == CSR_MCYCLE)) begin
      r_mcycle <= CSR_Write_Data;
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
    end
  end
`endif

  always_comb begin
    w_rdata = '0;
    case (CSR_Read_Addr)
      CSR_MSTATUS:  w_rdata = w_mstatus;
      CSR_MTVEC:    w_rdata = r_mtvec;
      CSR_MSCRATCH: w_rdata = r_mscratch;
      CSR_MEPC:     w_rdata = r_mepc;
      CSR_MCAUSE:   w_rdata = r_mcause;
`ifdef CSR_MCYCLE_EN
      CSR_MCYCLE:   w_rdata = r_mcycle;
`endif
      default:      w_rdata = '0;
    endcase
  end

  assign CSR_Read_Data     = w_rdata;
  assign mstatus_Read_Data = w_mstatus;
  assign mtvec_Read_Data   = r_mtvec;
  assign mepc_Read_Data    = r_mepc;
  assign mcause_Read_Data  = r_mcause;

endmodule

// File: doc/csr_regfile.md
# csr_regfile

Machine-mode control and status register file for the NPC RV64 core: the responder side of the ALU's CSR port. It serves combinational CSR reads addressed by the ALU and commits generic CSR writes (csrrw/csrrs/csrrc results) as well as dedicated mepc/mcause/mtvec updates on the clock edge. It also sequences the mstatus interrupt-enable stack on trap entry and mret, and optionally provides a free-running mcycle counter. It sits beside the register file and is driven by the ALU and CU.

## Interface
Parameters:
- XLEN, 64, register width (only 64 supported)
- MSTATUS_RST, 64'h0000_000a_0000_1800, mstatus reset value (MPP=11, UXL/SXL=10)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- CSR_Read_Addr  in  12  read address from ALU
- CSR_Read_Data  out  64  combinational read data
- CSR_Write_Addr  in  12  generic write address
- CSR_Write_Data  in  64  generic write data
- Write_En  in  1  generic write strobe
- mcause_Write_Data / mepc_Write_Data / mtvec_Write_Data  in  64 each  dedicated write data
- mcause_En / mepc_En / mtvec_En  in  1 each  dedicated write strobes
- mcause_Read_Data / mepc_Read_Data / mtvec_Read_Data  out  64 each  direct register views
- Trap_En  in  1  trap entry (ecall) this cycle; CU-driven
- Mret_En  in  1  mret retire this cycle; CU-driven
- mstatus_Read_Data  out  64  direct mstatus view

## Operation
- Address map: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00 (macro-gated).
- Read: pure combinational decode of CSR_Read_Addr; unmapped address returns 64'd0.
- Write masks: mtvec[1:0] forced 00 (direct mode); mepc[0] forced 0; mstatus writable bits MIE[3], MPIE[7] only, all other bits hold MSTATUS_RST values; mcause, mscratch fully writable. Unmapped writes ignored.
- Trap_En: MPIE<=MIE, MIE<=0. mepc/mcause themselves arrive via dedicated strobes in the same cycle.
- Mret_En: MIE<=MPIE, MPIE<=1.
- Per-register write priority, highest first: Trap_En/Mret_En (mstatus only) > dedicated strobe > generic Write_En. Trap_En and Mret_En together: Trap_En wins, Mret_En dropped.
- Dedicated strobe and generic write to the same register in one cycle: dedicated data committed, generic discarded.

## Timing
- All state updates on rising clk; write visible to reads the following cycle. No write-to-read bypass: same-cycle read returns the old value.
- Reset (any cycle, including mid-trap): mstatus=MSTATUS_RST, mtvec=mepc=mcause=mscratch=0, mcycle=0. All read outputs reflect these values in the first cycle after rst deasserts; strobes sampled during rst are ignored.
- Zero latency read path; one-cycle write path; no stall or handshake outputs.

## Configuration
- CSR_MCYCLE_EN defined: 64-bit mcycle at 0xB00 increments by 1 every cycle rst is low; wraps 2^64-1 -> 0; a generic write in a cycle loads the written value and suppresses that cycle's increment.
- Undefined: 0xB00 is unmapped (reads 0, writes ignored), no counter flops.

## Structure
- Shared package csr_pkg: 12-bit address constants (CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MCYCLE), mstatus bit indices (MIE=3, MPIE=7), MSTATUS_WMASK=64'h88.
- One natural sub-module: csr_mstatus_ctrl (MIE/MPIE stack with trap/mret/write priority). All else flat.

## Test plan
- Reset then read all addresses -> mstatus 0x0000000a00001800, others 0; read 0x7C0 -> 0.
- Write_En to 0x305 with 0x80000003 -> next cycle mtvec_Read_Data=0x80000000; same-cycle read still 0.
- Write 0x341=0x1000 and mepc_En with 0x2001 same cycle -> mepc=0x2000.
- Write mstatus 0xFFFFFFFFFFFFFFFF -> reads 0x0000000a00001888; Trap_En -> 0x0000000a00001880; Mret_En -> 0x0000000a00001888.
- Trap_En and Mret_En together with MIE=1 -> MIE=0, MPIE=1.
- CSR_MCYCLE_EN: write 0xB00=0xFFFFFFFFFFFFFFFE -> reads ...FE, ...FF, then 0; assert rst mid-count -> 0.
